pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial frame transmitter that drives the single-bit input of the team's 1010 Moore sequence detector. It accepts a parallel payload through a start/ready handshake and emits one frame MSB-first on `dout`:
- a fixed 4-bit sync pattern `1,0,1,0`;
- DATA_W payload bits;
- a guard gap of zeros.

It is the stimulus/link end of the detector path and is registered throughout.

## Interface
- `DATA_W`, default 8: payload width in bits, minimum 1.
- `GAP`, default 2: number of guard cycles after each frame during which `dout` = 0, minimum 1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  frame request, sampled on a rising edge of `clk` only while `ready` = 1.
- `data_in`  in  DATA_W  payload, captured on the edge that accepts `start`.
- `ready`  out  1  high when in IDLE and `rst` = 0.
- `dout`  out  1  serial bit stream, registered.
- `busy`  out  1  high in SYNC, DATA and GAP.
- `frame_done`  out  1  one-cycle pulse after the last payload bit.
- `frame_cnt`  out  8  number of completed frames, modulo 256.

## Operation
- Moore FSM with states IDLE, SYNC, DATA and GAP.
- A bit counter tracks position in SYNC and DATA and counts guard cycles in GAP. Size it for max(4, DATA_W, GAP).
- IDLE:
  - `dout` = 0.
  - On `start` = 1, latch `data_in` into a shift register, clear the counter and go to SYNC.
- SYNC:
  - Emit `1,0,1,0` in that order, one bit per cycle.
  - After the 4th bit, go to DATA.
- DATA:
  - Emit `shift[DATA_W-1]` and shift left each cycle.
  - After DATA_W bits, go to GAP.
- GAP:
  - `dout` = 0 for GAP cycles, then go to IDLE.
- `frame_done` = 1 exactly in the first GAP cycle. `frame_cnt` increments at the edge entering GAP and wraps from 255 to 0.
- `start` while `busy` = 1 is ignored. It is neither queued nor does it corrupt the latched payload.
- `data_in` changes after acceptance have no effect on the frame in progress.
- `start` held high continuously sends back-to-back frames, each separated by exactly GAP zero cycles plus one IDLE cycle.
- Reset (asynchronous, any state), immediately on assertion without waiting for a clock edge:
  - state = IDLE, `dout` = 0, `busy` = 0, `frame_done` = 0, `frame_cnt` = 0, shift register = 0.
  - `ready` = 0 while `rst` = 1, and `ready` = 1 once `rst` deasserts.
  - A frame interrupted by reset is aborted and not counted.

## Timing
- Let edge E be the clock edge at which `start` = 1 and `ready` = 1. Cycle n is the cycle after edge E+n-1.
- Cycles 1..4: `dout` = 1,0,1,0. `busy` = 1 and `ready` = 0 from cycle 1.
- Cycles 5..4+DATA_W: payload bits, MSB first.
- Cycles 5+DATA_W..4+DATA_W+GAP: `dout` = 0. `frame_done` = 1 only in cycle 5+DATA_W.
- Cycle 5+DATA_W+GAP: IDLE, `ready` = 1, `busy` = 0. The earliest next acceptance is the edge ending this cycle.
- Latency from accepting edge to first sync bit on `dout`: 1 cycle.
- Frame period with `start` held high: 5+DATA_W+GAP cycles. This is 15 with the defaults.
- All outputs are glitch-free registered values or decodes of registered state, and never depend combinationally on `start` or `data_in`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → outputs are 0 immediately, without waiting for an edge; after release, `ready` = 1 and `frame_cnt` = 0.
- Single frame: `data_in` = 0xA5 with `start` pulsed for 1 cycle → `dout` = 1010 10100101 00, then `ready` = 1. `frame_done` pulses in cycle 13 and `frame_cnt` = 1.
- Back-to-back frames: `start` held high, `data_in` = 0x3C then 0xFF → second sync bit 1 appears in cycle 16. The two frames are separated by exactly 2 zeros plus 1 idle 0, and `frame_cnt` = 2.
- Busy/abort:
  - `start` pulsed in cycle 7 with `data_in` = 0x00 during a 0xA5 frame → no effect: the frame completes unchanged and `frame_cnt` increments once.
  - `rst` asserted in cycle 8 of a frame → `dout` = 0 immediately, `frame_cnt` unchanged, and no `frame_done` pulse.
- Wrap: send 256 frames → `frame_cnt` reads 255, then 0 after frame 256.
- Loopback: feed `dout` into the 1010 detector with `data_in` = 0x00 → the detector output pulses exactly once, in the cycle after the edge that samples sync bit 4 (cycle 5 relative to E+1). No further pulses occur during payload or gap.

Source files
------------

// File: rtl/pattern_tx.sv
// pattern_tx -- serial frame transmitter for the 1010 sequence-detector path.
//
// Accepts a DATA_W-bit payload through a start/ready handshake and sends one
// frame MSB-first on dout_o: sync pattern 1,0,1,0, then the payload bits, then
// GAP guard cycles of zeros. Every output is a register or a decode of
// registered state, so nothing depends combinationally on start_i or data_in_i.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   start_i        frame request, honoured only while ready_o = 1
//   data_in_i      payload, captured on the edge that accepts start_i
//   ready_o        high in IDLE while rst_i is low
//   dout_o         registered serial bit stream
//   busy_o         high in SYNC, DATA and GAP
//   frame_done_o   one-cycle pulse in the first guard cycle
//   frame_cnt_o    completed frames, modulo 256
module pattern_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              ready_o,
    output logic              dout_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [7:0]        frame_cnt_o
);

    // The counter spans sync position, payload position and guard cycles.
    localparam int MAX_A = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAX_C = (GAP > MAX_A) ? GAP : MAX_A;
    localparam int CW    = $clog2(MAX_C);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(3);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              dout_q, dout_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              accept_s;

    assign accept_s = (state_q == ST_IDLE) && start_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each phase ends when the counter reaches its last index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_SYNC;
                else          state_d = ST_IDLE;
            end
            ST_SYNC: begin
                if (cnt_q == SYNC_LAST) state_d = ST_DATA;
                else                    state_d = ST_SYNC;
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) state_d = ST_GAP;
                else                    state_d = ST_DATA;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic. dout_d is the bit for the *next* cycle, so the
    // registered dout_q shows the first sync bit one cycle after acceptance.
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_d = data_in_i;
                    cnt_d   = CNT_ZERO;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    cnt_d   = CNT_ZERO;
                    dout_d  = shift_q[DATA_W-1];
                    shift_d = shift_q << 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    // Sync bit at index k is ~k[0]; the next index is cnt_q+1.
                    dout_d  = cnt_q[0];
                end
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d        = CNT_ZERO;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    dout_d  = shift_q[DATA_W-1];
                    shift_d = shift_q << 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) cnt_d = CNT_ZERO;
                else                   cnt_d = cnt_q + CNT_ONE;
            end
            default: begin
                cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= CNT_ZERO;
            shift_q      <= '0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dout_o       = dout_q;
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign ready_o      = (state_q == ST_IDLE) && !rst_i;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: expected serial bits are queued when a frame
// is requested and popped one per cycle as the frame goes out.
module tb_pattern_tx;

    localparam int DW    = 8;
    localparam int GP    = 2;
    localparam int FRAME = 4 + DW + GP;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          ready;
    logic          dout;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       sb[$];

    // Reference 1010 Moore detector (overlapping) driven by dout.
    logic [2:0] det_s;
    logic       det;

    pattern_tx #(.DATA_W(DW), .GAP(GP)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .data_in_i    (data_in),
        .ready_o      (ready),
        .dout_o       (dout),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .frame_cnt_o  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector state: 0 none, 1 "1", 2 "10", 3 "101", 4 "1010".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_s <= 3'd0;
        end else begin
            case (det_s)
                3'd0:    det_s <= dout ? 3'd1 : 3'd0;
                3'd1:    det_s <= dout ? 3'd1 : 3'd2;
                3'd2:    det_s <= dout ? 3'd3 : 3'd0;
                3'd3:    det_s <= dout ? 3'd1 : 3'd4;
                3'd4:    det_s <= dout ? 3'd3 : 3'd0;
                default: det_s <= 3'd0;
            endcase
        end
    end
    assign det = (det_s == 3'd4);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has driven start=1 and data_in=d at a negedge while ready=1.
    // keep: leave start high; inj: cycle in which a spurious start with 0x00
    // is driven; abort_at: cycle in which rst is asserted mid-cycle; chk_det:
    // compare the detector reference output as well.
    task automatic do_frame(input logic [DW-1:0] d, input bit keep, input int inj,
                            input int abort_at, input bit chk_det);
        logic e;
        for (int i = 0; i < 4; i++) sb.push_back(((i % 2) == 0) ? 1'b1 : 1'b0);
        for (int i = DW - 1; i >= 0; i--) sb.push_back(d[i]);
        for (int i = 0; i < GP; i++) sb.push_back(1'b0);
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            if (n == 5 + DW) exp_cnt = exp_cnt + 8'd1;
            chk("dout", {31'd0, dout}, {31'd0, e});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("ready", {31'd0, ready}, 32'd0);
            chk("frame_done", {31'd0, frame_done}, (n == 5 + DW) ? 32'd1 : 32'd0);
            chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
            if (chk_det) chk("detector", {31'd0, det}, (n == 5) ? 32'd1 : 32'd0);
            if (n == 1 && !keep) start = 1'b0;
            if (n == 2) data_in = ~d;
            if (inj != 0 && n == inj) begin
                start   = 1'b1;
                data_in = '0;
            end
            if (inj != 0 && n == inj + 1) start = 1'b0;
            if (n == abort_at) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("abort_dout", {31'd0, dout}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, frame_done}, 32'd0);
                chk("abort_ready", {31'd0, ready}, 32'd0);
                chk("abort_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
                sb.delete();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_dout", {31'd0, dout}, 32'd0);
        chk("idle_done", {31'd0, frame_done}, 32'd0);
        if (chk_det) chk("idle_det", {31'd0, det}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_cnt", {24'd0, frame_cnt}, 32'd0);
        @(negedge clk);

        // Frame aborted by reset in cycle 8 (0xFF keeps dout high there).
        start   = 1'b1;
        data_in = 8'hFF;
        do_frame(8'hFF, 1'b0, 0, 8, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("post_abort_done", {31'd0, frame_done}, 32'd0);
            chk("post_abort_dout", {31'd0, dout}, 32'd0);
            chk("post_abort_cnt", {24'd0, frame_cnt}, 32'd0);
        end

        // Single frame 0xA5.
        start   = 1'b1;
        data_in = 8'hA5;
        do_frame(8'hA5, 1'b0, 0, 0, 1'b0);
        chk("single_cnt", {24'd0, frame_cnt}, 32'd1);

        // Spurious start with 0x00 in cycle 7 of a 0xA5 frame.
        start   = 1'b1;
        data_in = 8'hA5;
        do_frame(8'hA5, 1'b0, 7, 0, 1'b0);
        chk("busy_start_cnt", {24'd0, frame_cnt}, 32'd2);

        // Back-to-back frames with start held.
        start   = 1'b1;
        data_in = 8'h3C;
        do_frame(8'h3C, 1'b1, 0, 0, 1'b0);
        data_in = 8'hFF;
        do_frame(8'hFF, 1'b0, 0, 0, 1'b0);
        chk("b2b_cnt", {24'd0, frame_cnt}, 32'd4);

        // Loopback into the 1010 detector with an all-zero payload.
        start   = 1'b1;
        data_in = 8'h00;
        do_frame(8'h00, 1'b0, 0, 0, 1'b1);

        // Counter wrap: 256 frames after a fresh reset.
        #2 rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        start = 1'b1;
        for (int f = 1; f <= 256; f++) begin
            data_in = DW'($urandom_range(0, 255));
            do_frame(data_in, 1'b1, 0, 0, 1'b0);
            if (f == 255) chk("wrap_255", {24'd0, frame_cnt}, 32'd255);
            if (f == 256) chk("wrap_0", {24'd0, frame_cnt}, 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("final_ready", {31'd0, ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
